periph_write_queue: RTL and testbench

PERIPH_WRITE_QUEUE -- requirements
Module: periph_write_queue

---
 rtl/periph_write_queue.sv | 121 ++++++++++++
 tb/tb_periph_write_queue.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/periph_write_queue.sv
// Posted-write queue between a memory controller and a peripheral AXI master.
// Writes are buffered in a FIFO and drained in order. Reads wait until every earlier write is done.
module periph_write_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [ADDR_WIDTH-1:0]     U_Addr,
    input  logic                      U_StartWrite,
    input  logic                      U_StartRead,
    input  logic [DATA_WIDTH-1:0]     U_WriteData,
    output logic                      U_WriteCompleted,
    output logic                      U_ReadCompleted,
    output logic [DATA_WIDTH-1:0]     U_ReadData,
    output logic [ADDR_WIDTH-1:0]     P_AXIAddr,
    output logic [DATA_WIDTH-1:0]     P_WriteData,
    output logic                      P_StartAXIWrite,
    output logic                      P_StartAXIRead,
    input  logic                      P_WriteCompleted,
    input  logic                      P_ReadCompleted,
    input  logic [DATA_WIDTH-1:0]     P_ReadData,
    output logic [$clog2(DEPTH):0]    Count,
    output logic                      Full,
    output logic                      Empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StWrWait, StRdWait} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q;
    logic [PtrW-1:0]       rd_ptr_q;
    logic [CntW-1:0]       count_q;
    logic                  push;
    logic                  pop;
    logic                  start_read;

    assign Count = count_q;
    assign Full  = (count_q == FullCount);
    assign Empty = (count_q == '0);

    // A start still high during its own completion pulse belongs to the finished request.
    assign push = U_StartWrite && !Full && !U_WriteCompleted;
    assign pop  = (state_q == StIdle) && !Empty;
    // A write accepted this cycle is older than the read, so the read must wait for it.
    assign start_read = (state_q == StIdle) && Empty && U_StartRead && !push && !U_ReadCompleted;

    always_ff @(posedge Clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= U_Addr;
            data_mem[wr_ptr_q] <= U_WriteData;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q          <= StIdle;
            U_WriteCompleted <= 1'b0;
            U_ReadCompleted  <= 1'b0;
            U_ReadData       <= '0;
            P_AXIAddr        <= '0;
            P_WriteData      <= '0;
            P_StartAXIWrite  <= 1'b0;
            P_StartAXIRead   <= 1'b0;
        end else begin
            U_WriteCompleted <= push;
            U_ReadCompleted  <= 1'b0;
            P_StartAXIWrite  <= 1'b0;
            P_StartAXIRead   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        P_AXIAddr       <= addr_mem[rd_ptr_q];
                        P_WriteData     <= data_mem[rd_ptr_q];
                        P_StartAXIWrite <= 1'b1;
                        state_q         <= StWrWait;
                    end else if (start_read) begin
                        P_AXIAddr      <= U_Addr;
                        P_StartAXIRead <= 1'b1;
                        state_q        <= StRdWait;
                    end
                end
                StWrWait: begin
                    if (P_WriteCompleted) state_q <= StIdle;
                end
                StRdWait: begin
                    if (P_ReadCompleted) begin
                        U_ReadData      <= P_ReadData;
                        U_ReadCompleted <= 1'b1;
                        state_q         <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_periph_write_queue.sv
// Self-checking bench for periph_write_queue: upstream requester, peripheral AXI model and
// scoreboards of expected AXI writes and read results.
module tb_periph_write_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic          Clk = 1'b0;
    logic          Rst;
    logic [AW-1:0] U_Addr;
    logic          U_StartWrite;
    logic          U_StartRead;
    logic [DW-1:0] U_WriteData;
    logic          U_WriteCompleted;
    logic          U_ReadCompleted;
    logic [DW-1:0] U_ReadData;
    logic [AW-1:0] P_AXIAddr;
    logic [DW-1:0] P_WriteData;
    logic          P_StartAXIWrite;
    logic          P_StartAXIRead;
    logic          P_WriteCompleted;
    logic          P_ReadCompleted;
    logic [DW-1:0] P_ReadData;
    logic [2:0]    Count;
    logic          Full;
    logic          Empty;

    periph_write_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .Clk              (Clk),
        .Rst              (Rst),
        .U_Addr           (U_Addr),
        .U_StartWrite     (U_StartWrite),
        .U_StartRead      (U_StartRead),
        .U_WriteData      (U_WriteData),
        .U_WriteCompleted (U_WriteCompleted),
        .U_ReadCompleted  (U_ReadCompleted),
        .U_ReadData       (U_ReadData),
        .P_AXIAddr        (P_AXIAddr),
        .P_WriteData      (P_WriteData),
        .P_StartAXIWrite  (P_StartAXIWrite),
        .P_StartAXIRead   (P_StartAXIRead),
        .P_WriteCompleted (P_WriteCompleted),
        .P_ReadCompleted  (P_ReadCompleted),
        .P_ReadData       (P_ReadData),
        .Count            (Count),
        .Full             (Full),
        .Empty            (Empty)
    );

    always #5 Clk = ~Clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [AW+DW-1:0] exp_wr [$];
    logic [DW-1:0]    exp_rd [$];
    logic [AW-1:0]    exp_rd_addr = '0;

    int            wr_latency = 3;
    int            rd_latency = 2;
    int            wr_timer   = 0;
    int            rd_timer   = 0;
    bit            hold_wr    = 1'b0;
    bit            spur_rd    = 1'b0;
    logic [DW-1:0] rd_value   = '0;

    int n_axi_wr   = 0;
    int n_axi_rd   = 0;
    int n_wr_pulse = 0;
    int max_count  = 0;

    // Monitor first, then the peripheral model drives its completion pulses for the next edge.
    initial begin
        logic [AW+DW-1:0] e;
        logic [DW-1:0]    r;
        P_WriteCompleted = 1'b0;
        P_ReadCompleted  = 1'b0;
        P_ReadData       = '0;
        forever begin
            @(negedge Clk);
            if (!Rst) begin
                if (int'(Count) > max_count) max_count = int'(Count);
                if (U_WriteCompleted) n_wr_pulse++;
                if (P_StartAXIWrite) begin
                    n_axi_wr++;
                    n_total++;
                    if (exp_wr.size() == 0) begin
                        $display("FAIL axi_write_order: got %h/%h, required no write",
                                 P_AXIAddr, P_WriteData);
                    end else begin
                        e = exp_wr.pop_front();
                        if ({P_AXIAddr, P_WriteData} !== e)
                            $display("FAIL axi_write_order: got %h/%h, required %h/%h",
                                     P_AXIAddr, P_WriteData, e[AW+DW-1:DW], e[DW-1:0]);
                        else n_pass++;
                    end
                end
                if (P_StartAXIRead) begin
                    n_axi_rd++;
                    n_total++;
                    if (P_AXIAddr !== exp_rd_addr || exp_wr.size() != 0 || wr_timer != 0)
                        $display("FAIL axi_read_start: addr %h pending_writes %0d busy %0d, required addr %h with 0 pending",
                                 P_AXIAddr, exp_wr.size(), wr_timer, exp_rd_addr);
                    else n_pass++;
                end
                if (U_ReadCompleted) begin
                    n_total++;
                    if (exp_rd.size() == 0) begin
                        $display("FAIL read_result: got pulse with %h, required no pulse", U_ReadData);
                    end else begin
                        r = exp_rd.pop_front();
                        if (U_ReadData !== r)
                            $display("FAIL read_result: got %h, required %h", U_ReadData, r);
                        else n_pass++;
                    end
                end
            end
            P_WriteCompleted = 1'b0;
            P_ReadCompleted  = 1'b0;
            if (wr_timer > 0 && !(hold_wr && wr_timer == 1)) begin
                wr_timer--;
                if (wr_timer == 0) P_WriteCompleted = 1'b1;
            end
            if (rd_timer > 0) begin
                rd_timer--;
                if (rd_timer == 0) begin
                    P_ReadData      = rd_value;
                    P_ReadCompleted = 1'b1;
                end
            end
            if (spur_rd) begin
                P_ReadData      = 32'hBAD0_BAD0;
                P_ReadCompleted = 1'b1;
                spur_rd         = 1'b0;
            end
            if (P_StartAXIWrite && !Rst) wr_timer = wr_latency;
            if (P_StartAXIRead && !Rst)  rd_timer = rd_latency;
        end
    end

    task automatic start_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        U_Addr       = a;
        U_WriteData  = d;
        U_StartWrite = 1'b1;
        exp_wr.push_back({a, d});
    endtask

    // Returns negedges waited until U_WriteCompleted, or -1 on timeout.
    task automatic wait_write(input int bound, output int lat);
        lat = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge Clk);
            if (U_WriteCompleted) begin
                lat = i;
                break;
            end
        end
        U_StartWrite = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (exp_wr.size() == 0 && wr_timer == 0 && rd_timer == 0) break;
        end
        if (i == 200) begin
            n_total++;
            $display("FAIL drain_timeout: pending %0d, required 0", exp_wr.size());
        end
        repeat (3) @(negedge Clk);
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        U_Addr = '0; U_StartWrite = 1'b0; U_StartRead = 1'b0; U_WriteData = '0;
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        n_total++; if (Count !== 3'd0) $display("FAIL reset_count: got %0d, required 0", Count); else n_pass++;
        n_total++; if (Empty !== 1'b1) $display("FAIL reset_empty: got %b, required 1", Empty); else n_pass++;
        n_total++; if (Full !== 1'b0) $display("FAIL reset_full: got %b, required 0", Full); else n_pass++;
        n_total++;
        if ({U_WriteCompleted, U_ReadCompleted, P_StartAXIWrite, P_StartAXIRead} !== 4'b0)
            $display("FAIL reset_pulses: got %b%b%b%b, required 0000", U_WriteCompleted,
                     U_ReadCompleted, P_StartAXIWrite, P_StartAXIRead);
        else n_pass++;
        n_total++; if (P_AXIAddr !== '0) $display("FAIL reset_axi_addr: got %h, required 0", P_AXIAddr); else n_pass++;
        n_total++; if (P_WriteData !== '0) $display("FAIL reset_wdata: got %h, required 0", P_WriteData); else n_pass++;
        n_total++; if (U_ReadData !== '0) $display("FAIL reset_rdata: got %h, required 0", U_ReadData); else n_pass++;
    endtask

    task automatic test_single_write();
        int lat;
        int base = n_axi_wr;
        wr_latency = 3;
        start_write(32'h4000_0010, 32'hDEAD_BEEF);
        wait_write(10, lat);
        n_total++; if (lat !== 1) $display("FAIL single_ack_latency: got %0d, required 1", lat); else n_pass++;
        n_total++; if (Count !== 3'd1) $display("FAIL single_count_up: got %0d, required 1", Count); else n_pass++;
        @(negedge Clk);
        n_total++; if (P_StartAXIWrite !== 1'b1) $display("FAIL single_axi_start: got %b, required 1", P_StartAXIWrite); else n_pass++;
        n_total++; if (Count !== 3'd0) $display("FAIL single_count_down: got %0d, required 0", Count); else n_pass++;
        wait_idle();
        n_total++; if (n_axi_wr - base !== 1) $display("FAIL single_axi_count: got %0d, required 1", n_axi_wr - base); else n_pass++;
    endtask

    task automatic test_back_to_back_full();
        int lat;
        bit stalled = 1'b1;
        int base = n_axi_wr;
        hold_wr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            start_write(32'h4000_1000 + 32'(i * 4), $urandom);
            wait_write(10, lat);
            n_total++;
            if (lat !== (i == 0 ? 1 : 2))
                $display("FAIL b2b_ack_latency%0d: got %0d, required %0d", i, lat, (i == 0 ? 1 : 2));
            else n_pass++;
        end
        n_total++; if (Full !== 1'b1 || Count !== 3'd4) $display("FAIL b2b_full: got full %b count %0d, required 1/4", Full, Count); else n_pass++;
        start_write(32'h4000_1014, 32'hCAFE_0006);
        repeat (8) begin
            @(negedge Clk);
            if (U_WriteCompleted) stalled = 1'b0;
        end
        n_total++; if (stalled !== 1'b1) $display("FAIL b2b_stall: got ack while full, required none"); else n_pass++;
        hold_wr = 1'b0;
        wait_write(20, lat);
        n_total++; if (lat < 1) $display("FAIL b2b_resume: got timeout, required ack after slot frees"); else n_pass++;
        wait_idle();
        n_total++; if (n_axi_wr - base !== 6) $display("FAIL b2b_axi_count: got %0d, required 6", n_axi_wr - base); else n_pass++;
    endtask

    task automatic test_write_then_read();
        int lat;
        int i;
        int base = n_axi_rd;
        wr_latency = 3;
        for (int k = 0; k < 3; k++) begin
            start_write(32'h4000_2000 + 32'(k * 4), 32'hA5A5_0000 + 32'(k));
            wait_write(10, lat);
            n_total++; if (lat < 1) $display("FAIL wr_rd_write%0d: got timeout, required ack", k); else n_pass++;
        end
        exp_rd_addr = 32'h4000_0020;
        rd_value    = 32'h1234_5678;
        exp_rd.push_back(32'h1234_5678);
        U_Addr      = 32'h4000_0020;
        U_StartRead = 1'b1;
        for (i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (U_ReadCompleted) break;
        end
        U_StartRead = 1'b0;
        n_total++; if (i == 100) $display("FAIL wr_rd_read_done: got timeout, required read pulse"); else n_pass++;
        n_total++; if (U_ReadData !== 32'h1234_5678) $display("FAIL wr_rd_data: got %h, required 12345678", U_ReadData); else n_pass++;
        @(negedge Clk);
        n_total++; if (U_ReadCompleted !== 1'b0) $display("FAIL wr_rd_pulse_width: got %b, required 0", U_ReadCompleted); else n_pass++;
        wait_idle();
        n_total++; if (n_axi_rd - base !== 1) $display("FAIL wr_rd_axi_reads: got %0d, required 1", n_axi_rd - base); else n_pass++;
    endtask

    task automatic test_spurious_read();
        bit pulsed = 1'b0;
        spur_rd = 1'b1;
        repeat (4) begin
            @(negedge Clk);
            if (U_ReadCompleted) pulsed = 1'b1;
        end
        n_total++; if (pulsed !== 1'b0) $display("FAIL spurious_pulse: got pulse, required none"); else n_pass++;
        n_total++; if (U_ReadData !== 32'h1234_5678) $display("FAIL spurious_rdata: got %h, required 12345678", U_ReadData); else n_pass++;
    endtask

    task automatic test_push_pop_wrap();
        int lat;
        int base = n_axi_wr;
        wr_latency = 1;
        max_count  = 0;
        for (int i = 0; i < 2 * DEPTH + 1; i++) begin
            start_write(32'h4000_3000 + 32'(i * 4), $urandom);
            wait_write(10, lat);
            n_total++; if (lat < 1) $display("FAIL wrap_ack%0d: got timeout, required ack", i); else n_pass++;
        end
        wait_idle();
        n_total++; if (n_axi_wr - base !== 2 * DEPTH + 1) $display("FAIL wrap_axi_count: got %0d, required %0d", n_axi_wr - base, 2 * DEPTH + 1); else n_pass++;
        n_total++; if (max_count > DEPTH) $display("FAIL wrap_max_count: got %0d, required <= %0d", max_count, DEPTH); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat;
        int axi_base;
        int ack_base;
        hold_wr    = 1'b1;
        wr_latency = 3;
        for (int i = 0; i < 4; i++) begin
            start_write(32'h4000_4000 + 32'(i * 4), 32'h5555_0000 + 32'(i));
            wait_write(10, lat);
        end
        n_total++; if (Count !== 3'd3) $display("FAIL rstmid_count_before: got %0d, required 3", Count); else n_pass++;
        #2 Rst = 1'b1;
        #1;
        n_total++;
        if (Count !== 3'd0 || Empty !== 1'b1 || Full !== 1'b0 || P_AXIAddr !== '0 || P_WriteData !== '0 ||
            U_WriteCompleted !== 1'b0 || P_StartAXIWrite !== 1'b0)
            $display("FAIL rstmid_async: got count %0d empty %b addr %h data %h, required 0/1/0/0",
                     Count, Empty, P_AXIAddr, P_WriteData);
        else n_pass++;
        exp_wr.delete();
        wr_timer = 0;
        hold_wr  = 1'b0;
        axi_base = n_axi_wr;
        ack_base = n_wr_pulse;
        @(negedge Clk);
        Rst = 1'b0;
        repeat (10) @(negedge Clk);
        n_total++; if (n_axi_wr !== axi_base) $display("FAIL rstmid_axi_after: got %0d starts, required 0", n_axi_wr - axi_base); else n_pass++;
        n_total++; if (n_wr_pulse !== ack_base) $display("FAIL rstmid_ack_after: got %0d acks, required 0", n_wr_pulse - ack_base); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back_full();
        test_write_then_read();
        test_spurious_read();
        test_push_pop_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by time limit, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
